// File: rtl/avalon_cpt_cpu_debug_pkg.sv
// Shared definitions for the debug scan master: FSM states, virtual IR codes, default widths.
// Latency: none (definitions only).
// Backpressure: not applicable.
package avalon_cpt_cpu_debug_pkg;

    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;

    // Virtual IR encodings understood by the Nios II debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACE     = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RESP = 3'd5
    } scan_state_e;

endpackage

// File: rtl/avalon_cpt_cpu_debug_scan_tckgen.sv
// Generates vji_tck (low half then high half, TCK_DIV clk cycles each) plus edge-ahead pulses.
// Latency: period_start/tck_rise are high in the cycle before the edge that starts a period / raises tck.
// Backpressure: none; counter and tck sit at 0 while run is low.
module avalon_cpt_cpu_debug_scan_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic vji_tck,
    output logic period_start,
    output logic tck_rise
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(TCK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;

    // Next counter value wraps every 2*TCK_DIV cycles; tck is high for the upper half of the count
    always_comb begin
        cnt_d = '0;
        tck_d = 1'b0;
        if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            tck_d = (cnt_d >= CNT_HIGH);
        end
    end

    // Counter and tck flops; reset forces tck low without waiting for clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign vji_tck      = tck_q;
    assign period_start = run && (cnt_q == CNT_LAST);
    assign tck_rise     = run && (cnt_q == CNT_RISE);

endmodule

// File: rtl/avalon_cpt_cpu_debug_scan_master.sv
// Drives one virtual-JTAG IR/DR scan (UIR, CDR, SDR x DR_WIDTH, UDR) per accepted command.
// Latency: rsp_valid rises (DR_WIDTH+3)*2*TCK_DIV clk cycles after the accepting edge.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
module avalon_cpt_cpu_debug_scan_master
    import avalon_cpt_cpu_debug_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH);

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;
    logic                tdi_q, tdi_d;
    logic                cmd_ready_q, rsp_valid_q, busy_q, rti_q;
    logic                uir_q, cdr_q, sdr_q, udr_q;

    logic run, period_start, tck_rise;

    // tck only toggles while a scan is in progress
    assign run = (state_q != IDLE) && (state_q != RESP);

    avalon_cpt_cpu_debug_scan_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .vji_tck      (vji_tck),
        .period_start (period_start),
        .tck_rise     (tck_rise)
    );

    // Next-state: states advance on period boundaries, slave data is sampled on tck rise,
    // tdi only moves on the edge that opens a new (tck low) period
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        ir_in_d      = ir_in_q;
        tdi_d        = tdi_q;
        rsp_data_d   = rsp_data_q;
        rsp_ir_out_d = rsp_ir_out_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = UIR;
                    ir_in_d = cmd_ir;
                    sr_d    = cmd_data;
                end
            end
            UIR: begin
                if (tck_rise)     rsp_ir_out_d = vji_ir_out;
                if (period_start) state_d = CDR;
            end
            CDR: begin
                bit_cnt_d = '0;
                if (period_start) begin
                    state_d = SDR;
                    tdi_d   = sr_q[0];
                end
            end
            SDR: begin
                if (tck_rise) begin
                    sr_d      = {vji_tdo, sr_q[DR_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (period_start) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = UDR;
                        tdi_d   = 1'b0;
                    end else begin
                        tdi_d   = sr_q[0];
                    end
                end
            end
            UDR: begin
                if (period_start) begin
                    state_d    = RESP;
                    rsp_data_d = sr_q;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs (strobes decoded from the next state so they
    // cover exactly the periods spent in their state)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            ir_in_q      <= '0;
            tdi_q        <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ir_out_q <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            rti_q        <= 1'b1;
            uir_q        <= 1'b0;
            cdr_q        <= 1'b0;
            sdr_q        <= 1'b0;
            udr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            ir_in_q      <= ir_in_d;
            tdi_q        <= tdi_d;
            rsp_data_q   <= rsp_data_d;
            rsp_ir_out_q <= rsp_ir_out_d;
            cmd_ready_q  <= (state_d == IDLE);
            rsp_valid_q  <= (state_d == RESP);
            busy_q       <= (state_d != IDLE);
            rti_q        <= (state_d == IDLE);
            uir_q        <= (state_d == UIR);
            cdr_q        <= (state_d == CDR);
            sdr_q        <= (state_d == SDR);
            udr_q        <= (state_d == UDR);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign busy       = busy_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;
    assign vji_rti    = rti_q;

endmodule
